prog_loader: RTL and testbench

- Synthesizable boot/program loader for the 8-bit Harvard core.
- Optionally initialises the register bank to index values (rf[k]=k), streams instruction words into instruction memory over a valid/ready interface, and guarantees a HALT terminator word.
- Clears pc and releases the core from halted, then waits for the core to halt again.
- Parametrised in instruction width, instruction-memory depth and register-bank size/width.

---
 rtl/prog_loader.sv | 214 +++++++++++++++++++++
 tb/tb_prog_loader.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// Boot loader for the 8-bit Harvard core. It optionally seeds the register bank, streams the program into instruction memory, appends a HALT terminator when needed, and runs the core until it halts.
// Optional stream checksum check: define PROG_LOADER_CHECKSUM_EN.
module prog_loader #(
  parameter int             IW        = 32,
  parameter int             IADDR_W   = 6,
  parameter int             RF_DEPTH  = 32,
  parameter int             RF_AW     = 5,
  parameter int             DW        = 8,
  parameter logic [IW-1:0]  HALT_WORD = {IW{1'b1}}
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               init_rf,
  input  logic               s_valid,
  input  logic [IW-1:0]      s_data,
  input  logic               s_last,
  output logic               s_ready,
  output logic               imem_we,
  output logic [IADDR_W-1:0] imem_addr,
  output logic [IW-1:0]      imem_wdata,
  output logic               rf_we,
  output logic [RF_AW-1:0]   rf_addr,
  output logic [DW-1:0]      rf_wdata,
  output logic               pc_clr,
  output logic               core_run,
  input  logic               core_halted,
  output logic               busy,
  output logic               done,
  output logic               err_overflow,
  output logic [IADDR_W:0]   word_count
`ifdef PROG_LOADER_CHECKSUM_EN
  ,
  input  logic [IW-1:0]      exp_sum,
  output logic [IW-1:0]      sum,
  output logic               err_checksum
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RF_INIT,
    S_LOAD,
    S_TERM,
    S_RELEASE,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [IADDR_W:0] WC_FULL = {1'b1, {IADDR_W{1'b0}}};
  localparam logic [IADDR_W:0] WC_LAST = {1'b0, {IADDR_W{1'b1}}};
  localparam logic [RF_AW-1:0] RF_LAST = RF_AW'(RF_DEPTH - 1);

  state_t             state_q, state_d;
  logic [RF_AW-1:0]   rf_cnt_q, rf_cnt_d;
  logic [IADDR_W:0]   wc_q, wc_d;
  logic               ovf_q, ovf_d;
  logic               mem_full;
  logic               xfer;
  logic               ovf_now;
  logic               full_no_halt;
  logic               cks_bad;

`ifdef PROG_LOADER_CHECKSUM_EN
  logic [IW-1:0]      sum_q, sum_d;
  logic [IW-1:0]      exp_q, exp_d;
  logic               cks_err_q, cks_err_d;
`endif

  assign mem_full     = (wc_q == WC_FULL);
  assign xfer         = (state_q == S_LOAD) && s_valid;
  assign ovf_now      = ovf_q || mem_full;
  // The last word fills the final slot, so there is no room left for the terminator.
  assign full_no_halt = !ovf_now && (s_data != HALT_WORD) && (wc_q == WC_LAST);

`ifdef PROG_LOADER_CHECKSUM_EN
  assign cks_bad = ((sum_q + s_data) != exp_q);
`else
  assign cks_bad = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    rf_cnt_d = rf_cnt_q;
    wc_d     = wc_q;
    ovf_d    = ovf_q;
`ifdef PROG_LOADER_CHECKSUM_EN
    sum_d     = sum_q;
    exp_d     = exp_q;
    cks_err_d = cks_err_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          wc_d     = '0;
          ovf_d    = 1'b0;
          rf_cnt_d = '0;
`ifdef PROG_LOADER_CHECKSUM_EN
          sum_d     = '0;
          exp_d     = exp_sum;
          cks_err_d = 1'b0;
`endif
          state_d  = init_rf ? S_RF_INIT : S_LOAD;
        end
      end
      S_RF_INIT: begin
        rf_cnt_d = rf_cnt_q + RF_AW'(1);
        if (rf_cnt_q == RF_LAST) begin
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (xfer) begin
`ifdef PROG_LOADER_CHECKSUM_EN
          sum_d = sum_q + s_data;
`endif
          if (mem_full) begin
            ovf_d = 1'b1;
          end else begin
            wc_d = wc_q + (IADDR_W+1)'(1);
          end
          if (s_last) begin
            if (ovf_now || full_no_halt) begin
              ovf_d = 1'b1;
            end
`ifdef PROG_LOADER_CHECKSUM_EN
            if (cks_bad) begin
              cks_err_d = 1'b1;
            end
`endif
            if (ovf_now || full_no_halt || cks_bad) begin
              state_d = S_DONE;
            end else if (s_data == HALT_WORD) begin
              state_d = S_RELEASE;
            end else begin
              state_d = S_TERM;
            end
          end
        end
      end
      S_TERM: begin
        wc_d    = wc_q + (IADDR_W+1)'(1);
        state_d = S_RELEASE;
      end
      S_RELEASE: begin
        state_d = S_RUN;
      end
      S_RUN: begin
        if (core_halted) begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      rf_cnt_q <= '0;
      wc_q     <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rf_cnt_q <= rf_cnt_d;
      wc_q     <= wc_d;
      ovf_q    <= ovf_d;
    end
  end

`ifdef PROG_LOADER_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q     <= '0;
      cks_err_q <= 1'b0;
    end else begin
      sum_q     <= sum_d;
      cks_err_q <= cks_err_d;
    end
  end

  // Expected sum is data only; it is reloaded on every start.
  always_ff @(posedge clk) begin
    exp_q <= exp_d;
  end

  assign sum          = sum_q;
  assign err_checksum = cks_err_q;
`endif

  always_comb begin
    s_ready      = (state_q == S_LOAD);
    imem_we      = (xfer && !mem_full) || (state_q == S_TERM);
    imem_addr    = imem_we ? wc_q[IADDR_W-1:0] : '0;
    imem_wdata   = '0;
    if (state_q == S_TERM) begin
      imem_wdata = HALT_WORD;
    end else if (imem_we) begin
      imem_wdata = s_data;
    end
    rf_we        = (state_q == S_RF_INIT);
    rf_addr      = rf_we ? rf_cnt_q : '0;
    rf_wdata     = rf_we ? DW'(rf_cnt_q) : '0;
    pc_clr       = (state_q == S_RELEASE);
    core_run     = (state_q == S_RUN);
    busy         = (state_q != S_IDLE) && (state_q != S_DONE);
    done         = (state_q == S_DONE);
    err_overflow = ovf_q;
    word_count   = wc_q;
  end

endmodule

// File: tb/tb_prog_loader.sv
// Randomised bench for prog_loader: a transaction-level model predicts each load's writes, flags and release.
module tb_prog_loader;

  localparam int IW       = 32;
  localparam int IADDR_W  = 3;
  localparam int DEPTH    = 2**IADDR_W;
  localparam int RF_DEPTH = 32;
  localparam int RF_AW    = 5;
  localparam int DW       = 8;
  localparam logic [IW-1:0] HALT = {IW{1'b1}};
`ifdef PROG_LOADER_CHECKSUM_EN
  localparam bit CKS = 1'b1;
`else
  localparam bit CKS = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic               init_rf;
  logic               s_valid;
  logic [IW-1:0]      s_data;
  logic               s_last;
  logic               s_ready;
  logic               imem_we;
  logic [IADDR_W-1:0] imem_addr;
  logic [IW-1:0]      imem_wdata;
  logic               rf_we;
  logic [RF_AW-1:0]   rf_addr;
  logic [DW-1:0]      rf_wdata;
  logic               pc_clr;
  logic               core_run;
  logic               core_halted;
  logic               busy;
  logic               done;
  logic               err_overflow;
  logic [IADDR_W:0]   word_count;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [IW-1:0]      exp_sum;
  logic [IW-1:0]      sum;
  logic               err_checksum;
`endif

  prog_loader #(
    .IW(IW), .IADDR_W(IADDR_W), .RF_DEPTH(RF_DEPTH), .RF_AW(RF_AW), .DW(DW), .HALT_WORD(HALT)
  ) u_dut (
    .clk(clk), .rst(rst), .start(start), .init_rf(init_rf),
    .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .rf_we(rf_we), .rf_addr(rf_addr), .rf_wdata(rf_wdata),
    .pc_clr(pc_clr), .core_run(core_run), .core_halted(core_halted),
    .busy(busy), .done(done), .err_overflow(err_overflow), .word_count(word_count)
`ifdef PROG_LOADER_CHECKSUM_EN
    , .exp_sum(exp_sum), .sum(sum), .err_checksum(err_checksum)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [IADDR_W-1:0] a;
    logic [IW-1:0]      d;
  } wr_t;

  int          checks = 0;
  int          failures = 0;
  wr_t         exp_imem[$];
  wr_t         e;
  logic [IW-1:0] prog [0:15];
  logic [IW-1:0] mem_obs [0:DEPTH-1];
  int          rf_k = 0;
  int          pc_cnt = 0;
  logic        prev_run = 1'b0;
  logic        prev_pc = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, req);
    end
  endtask

  // Per-cycle observation of every write strobe against the predicted write list.
  always @(negedge clk) begin
    if (!rst) begin
      if (imem_we) begin
        mem_obs[imem_addr] = imem_wdata;
        if (exp_imem.size() == 0) begin
          chk("imem_unexpected_write", 1, 0);
        end else begin
          e = exp_imem.pop_front();
          chk("imem_addr", imem_addr, e.a);
          chk("imem_wdata", imem_wdata, e.d);
        end
      end
      if (rf_we) begin
        chk("rf_addr", rf_addr, rf_k[RF_AW-1:0]);
        chk("rf_wdata", rf_wdata, rf_k[DW-1:0]);
        chk("rf_s_ready", s_ready, 0);
        rf_k++;
      end
      if (pc_clr) pc_cnt++;
      if (core_run && !prev_run) chk("release_after_pc_clr", prev_pc, 1);
      prev_run = core_run;
      prev_pc  = pc_clr;
    end
  end

  task automatic run_load(input bit init, input int n, input bit cks_wrong, input bit abort_run);
    int            nw, exp_wc, cyc, i;
    bit            ovf, fullnh, term, err, cbad, rel;
    logic [IW-1:0] s, last;
    nw     = (n > DEPTH) ? DEPTH : n;
    ovf    = (n > DEPTH);
    last   = prog[n-1];
    s      = '0;
    for (int j = 0; j < n; j++) s += prog[j];
    cbad   = CKS && cks_wrong;
    fullnh = !ovf && (last != HALT) && (n == DEPTH);
    err    = ovf || fullnh;
    term   = !err && !cbad && (last != HALT);
    rel    = !err && !cbad;
    exp_wc = nw + (term ? 1 : 0);
    exp_imem.delete();
    for (int j = 0; j < nw; j++) exp_imem.push_back('{a: IADDR_W'(j), d: prog[j]});
    if (term) exp_imem.push_back('{a: IADDR_W'(nw), d: HALT});
    rf_k   = 0;
    pc_cnt = 0;

    @(posedge clk); #1;
    start   = 1'b1;
    init_rf = init;
`ifdef PROG_LOADER_CHECKSUM_EN
    exp_sum = cbad ? s + 1 : s;
`endif
    @(posedge clk); #1;
    start   = 1'b0;
    init_rf = 1'($urandom);
    chk("busy_after_start", busy, 1);

    i = 0;
    cyc = 0;
    while (i < n) begin
      s_valid = ($urandom_range(0, 3) != 0);
      s_data  = s_valid ? prog[i] : IW'($urandom);
      s_last  = s_valid ? (i == n - 1) : 1'($urandom);
      @(negedge clk);
      if (s_valid && s_ready) i++;
      @(posedge clk); #1;
      cyc++;
      if (cyc > 400) begin
        chk("stream_timeout", 0, 1);
        break;
      end
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_data  = '0;

    if (rel) begin
      cyc = 0;
      while (!core_run && cyc < 10) begin
        @(posedge clk); #1;
        cyc++;
      end
      chk("core_run_rise", core_run, 1);
      if (abort_run) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_core_run", core_run, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_word_count", word_count, 0);
        chk("abort_pc_cnt", pc_cnt, 1);
        exp_imem.delete();
        return;
      end
      repeat ($urandom_range(1, 4)) begin
        chk("core_run_hold", core_run, 1);
        chk("busy_in_run", busy, 1);
        start = 1'($urandom);
        @(posedge clk); #1;
      end
      start = 1'b0;
      chk("core_run_before_halt", core_run, 1);
      core_halted = 1'b1;
      @(posedge clk); #1;
      core_halted = 1'b0;
    end else begin
      cyc = 0;
      while (!done && cyc < 10) begin
        @(posedge clk); #1;
        cyc++;
      end
    end

    chk("done", done, 1);
    chk("core_run_end", core_run, 0);
    chk("busy_end", busy, 0);
    chk("word_count", word_count, exp_wc);
    chk("err_overflow", err_overflow, err);
    chk("imem_writes_missing", exp_imem.size(), 0);
    chk("rf_write_count", rf_k, init ? RF_DEPTH : 0);
    chk("pc_clr_count", pc_cnt, rel ? 1 : 0);
`ifdef PROG_LOADER_CHECKSUM_EN
    chk("sum", sum, s);
    chk("err_checksum", err_checksum, cbad);
`endif
  endtask

  initial begin
    int n;
    rst         = 1'b1;
    start       = 1'b0;
    init_rf     = 1'b0;
    s_valid     = 1'b1;
    s_data      = 32'h1234_5678;
    s_last      = 1'b1;
    core_halted = 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
    exp_sum     = '0;
`endif
    for (int j = 0; j < DEPTH; j++) mem_obs[j] = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_s_ready", s_ready, 0);
    chk("rst_imem_we", imem_we, 0);
    chk("rst_imem_addr", imem_addr, 0);
    chk("rst_imem_wdata", imem_wdata, 0);
    chk("rst_rf_we", rf_we, 0);
    chk("rst_rf_addr", rf_addr, 0);
    chk("rst_rf_wdata", rf_wdata, 0);
    chk("rst_pc_clr", pc_clr, 0);
    chk("rst_core_run", core_run, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err_overflow", err_overflow, 0);
    chk("rst_word_count", word_count, 0);
    rst     = 1'b0;
    s_valid = 1'b0;
    s_last  = 1'b0;

    // Program already ends in HALT: written as-is, no terminator.
    prog[0] = 32'h0020000A; prog[1] = 32'h00400014; prog[2] = 32'h0060001E;
    prog[3] = 32'h10040022; prog[4] = 32'h10050083; prog[5] = 32'hFFFFFFFF;
    run_load(1'b1, 6, 1'b0, 1'b0);
    chk("lit_t1_word_count", word_count, 6);
    chk("lit_t1_imem5", mem_obs[5], 32'hFFFFFFFF);
    chk("lit_t1_imem4", mem_obs[4], 32'h10050083);

    // Terminator appended after a non-HALT last word.
    prog[2] = 32'h10040022;
    run_load(1'b0, 3, 1'b0, 1'b0);
    chk("lit_t2_word_count", word_count, 4);
    chk("lit_t2_imem3", mem_obs[3], 32'hFFFFFFFF);
    chk("lit_t2_imem2", mem_obs[2], 32'h10040022);

    // Overflow: more words than slots.
    for (int j = 0; j < 10; j++) prog[j] = 32'h0100_0000 + j;
    run_load(1'b0, 10, 1'b0, 1'b0);
    chk("lit_t3_err_overflow", err_overflow, 1);
    chk("lit_t3_word_count", word_count, DEPTH);
    chk("lit_t3_core_run", core_run, 0);

    // Memory exactly full without HALT, then exactly full ending in HALT.
    run_load(1'b0, DEPTH, 1'b0, 1'b0);
    chk("lit_t4_err_overflow", err_overflow, 1);
    prog[DEPTH-1] = HALT;
    run_load(1'b0, DEPTH, 1'b0, 1'b0);
    chk("lit_t5_err_overflow", err_overflow, 0);

    // Reset while the core is running.
    prog[0] = 32'h0000_0042; prog[1] = HALT;
    run_load(1'b0, 2, 1'b0, 1'b1);

`ifdef PROG_LOADER_CHECKSUM_EN
    prog[0] = 32'h0020000A; prog[1] = 32'h00400014; prog[2] = 32'h10040022;
    run_load(1'b0, 3, 1'b1, 1'b0);
    run_load(1'b0, 3, 1'b0, 1'b0);
`endif

    for (int it = 0; it < 25; it++) begin
      n = $urandom_range(1, 11);
      for (int j = 0; j < n; j++) prog[j] = $urandom;
      if ($urandom_range(0, 2) == 0) prog[n-1] = HALT;
      run_load(($urandom_range(0, 3) == 0), n, ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
